oam_dma_ctrl: RTL and testbench

- Sprite DMA sequencer behind the CPU register $4014.
- On a CPU write of page P, it stalls the CPU via rdy and copies 256 bytes, P*256..P*256+255, from PRG space into OAM, starting at the current OAMADDR.
- It sits between the cpu core, the PRG memory port and the PPU OAM port, and arbitrates the PRG bus away from the CPU for the transfer.
- All sequencing advances only on CPU clock-enable pulses (ce_cpu).

---
 rtl/dendy_pkg.sv | 16 +
 rtl/oam_dma_ctrl_if.sv | 27 ++
 rtl/oam_dma_ctrl.sv | 88 ++++++++
 tb/tb_oam_dma_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dendy_pkg.sv
// Shared constants and state encoding for the sprite DMA sequencer behind $4014.
package dendy_pkg;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam int          OAM_LEN = 256;
    localparam int          CNT_W   = $clog2(OAM_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU core, the PRG read port and the PPU OAM write port.
interface oam_dma_ctrl_if;

    logic [15:0] cpu_a;
    logic [7:0]  cpu_o;
    logic        cpu_w;
    logic [7:0]  oam_start;
    logic        rdy;
    logic        busy;
    logic [15:0] dma_a;
    logic        dma_r;
    logic [7:0]  dma_i;
    logic [7:0]  oam_a;
    logic [7:0]  oam_d;
    logic        oam_w;

    modport master (
        input  cpu_a, cpu_o, cpu_w, oam_start, dma_i,
        output rdy, busy, dma_a, dma_r, oam_a, oam_d, oam_w
    );

    modport slave (
        output cpu_a, cpu_o, cpu_w, oam_start, dma_i,
        input  rdy, busy, dma_a, dma_r, oam_a, oam_d, oam_w
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: halts the CPU and copies one 256-byte PRG page into OAM, one step per ce.
//
// state | meaning
// IDLE  | CPU owns the bus, waiting for a write to DMA_REG
// HALT  | first stalled cycle, CPU finishing its current access
// ALIGN | extra dummy cycle so reads land on a get (phase=0) cycle
// READ  | PRG read of {page, cnt}
// WRITE | data from the previous read goes to OAM, counters advance
module oam_dma_ctrl
    import dendy_pkg::*;
(
    input  logic          clock25,
    input  logic          reset,
    input  logic          ce,
    oam_dma_ctrl_if.master bus
);

    dma_state_t       state;
    dma_state_t       state_nxt;
    logic             phase;
    logic [7:0]       page;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       oam_a_q;
    logic             trigger;
    logic             last_byte;

    // Only IDLE accepts a trigger, so a write to DMA_REG while busy cannot restart or re-page.
    assign trigger   = (state == IDLE) && ce && bus.cpu_w && (bus.cpu_a == DMA_REG);
    assign last_byte = (cnt == CNT_W'(OAM_LEN - 1));

    always_ff @(posedge clock25) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= 1'b0;
            page    <= '0;
            cnt     <= '0;
            oam_a_q <= '0;
        end else if (ce) begin
            phase <= ~phase;
            state <= state_nxt;
            if (trigger) begin
                page    <= bus.cpu_o;
                oam_a_q <= bus.oam_start;
                cnt     <= '0;
            end else if (state == WRITE) begin
                oam_a_q <= oam_a_q + 8'd1;
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = HALT;
            // phase flips on this ce; go straight to READ when the next cycle is a get cycle
            HALT:    state_nxt = phase ? READ : ALIGN;
            ALIGN:   state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = last_byte ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.rdy   = 1'b1;
        bus.busy  = 1'b0;
        bus.dma_r = 1'b0;
        bus.oam_w = 1'b0;
        bus.oam_d = '0;
        if (state != IDLE) begin
            bus.rdy  = 1'b0;
            bus.busy = 1'b1;
        end
        // strobes are also masked by reset so an aborted transfer leaves OAM untouched on that clock
        if (state == READ) begin
            bus.dma_r = ce && !reset;
        end
        if (state == WRITE) begin
            bus.oam_w = ce && !reset;
            bus.oam_d = bus.dma_i;
        end
    end

    assign bus.dma_a = {page, cnt};
    assign bus.oam_a = oam_a_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected reads/writes/stall lengths are queued at trigger time.
module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA_ADDR = 16'h4014;

    logic clock25 = 1'b0;
    logic reset;
    logic ce;

    oam_dma_ctrl_if bus();

    oam_dma_ctrl dut (
        .clock25 (clock25),
        .reset   (reset),
        .ce      (ce),
        .bus     (bus)
    );

    always #5 clock25 = ~clock25;

    int checks = 0;
    int errors = 0;

    logic [7:0]  prg [0:65535];
    logic [7:0]  oam_mem [0:255];
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    int          stall_q[$];

    bit   ph_m = 1'b0;
    bit   xfer_on = 1'b0;
    bit   was_busy = 1'b0;
    int   stall_cnt = 0;
    int   wr_count = 0;
    int   first_wa = -1;
    int   last_wa = -1;
    int   ce_div = 1;
    int   cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CPU-side phase: toggles on every ce clock out of reset; 0 is a get cycle.
    always @(posedge clock25) begin
        if (reset) ph_m <= 1'b0;
        else if (ce) ph_m <= ~ph_m;
    end

    // PRG memory: data valid on the ce cycle after the read strobe.
    always @(posedge clock25) begin
        if (bus.dma_r && ce) bus.dma_i <= prg[bus.dma_a];
    end

    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clock25);
            #1;
            cyc++;
            if (ce_div == 0) ce = 1'($urandom_range(0, 1));
            else if (ce_div == 1) ce = 1'b1;
            else ce = (cyc % ce_div == 0);
        end
    end

    always @(negedge clock25) begin
        logic [15:0] e;
        if (reset) begin
            was_busy  = 1'b0;
            stall_cnt = 0;
            chk("oam_w_in_reset", bus.oam_w, 0);
        end else begin
            if (!ce) chk("strobe_without_ce", {bus.dma_r, bus.oam_w}, 0);
            if (bus.dma_r) begin
                if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("dma_a", bus.dma_a, e);
                end
            end
            if (bus.oam_w) begin
                if (wr_q.size() == 0) chk("unexpected_oam_write", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("oam_a", bus.oam_a, e[15:8]);
                    chk("oam_d", bus.oam_d, e[7:0]);
                end
                if (wr_count == 0) first_wa = bus.oam_a;
                oam_mem[bus.oam_a] = bus.oam_d;
                last_wa = bus.oam_a;
                wr_count++;
            end
            if (ce && !bus.rdy) stall_cnt++;
            if (bus.rdy && was_busy) begin
                if (stall_q.size() == 0) chk("unexpected_stall", stall_cnt, 0);
                else chk("stall_ce_cycles", stall_cnt, stall_q.pop_front());
                chk("reads_left", rd_q.size(), 0);
                chk("writes_left", wr_q.size(), 0);
                stall_cnt = 0;
                xfer_on   = 1'b0;
            end
            was_busy = !bus.rdy;
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                             input bit use_par, input bit want);
        int n = 0;
        do begin
            @(negedge clock25);
            n++;
        end while (!(ce && (!use_par || ph_m == want)) && n < 200);
        if (n >= 200) chk("trigger_wait_timeout", n, 0);
        bus.cpu_a = a;
        bus.cpu_o = d;
        bus.cpu_w = 1'b1;
        if (a == DMA_ADDR && !xfer_on) begin
            for (int i = 0; i < 256; i++) begin
                rd_q.push_back({d, 8'(i)});
                wr_q.push_back({8'(bus.oam_start + 8'(i)), prg[{d, 8'(i)}]});
            end
            stall_q.push_back(513 + int'(ph_m));
            xfer_on  = 1'b1;
            wr_count = 0;
        end
        @(posedge clock25);
        #1;
        bus.cpu_w = 1'b0;
        bus.cpu_a = 16'h0000;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (xfer_on && n < budget) begin
            @(negedge clock25);
            n++;
        end
        chk("transfer_timeout", int'(xfer_on), 0);
        repeat (4) @(negedge clock25);
    endtask

    task automatic check_oam(input string name, input logic [7:0] page, input logic [7:0] start);
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (oam_mem[8'(start + 8'(i))] !== prg[{page, 8'(i)}]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic run_xfer(input string name, input logic [7:0] page, input logic [7:0] start,
                            input bit use_par, input bit want);
        bus.oam_start = start;
        cpu_write(DMA_ADDR, page, use_par, want);
        wait_done(6000);
        check_oam(name, page, start);
    endtask

    initial begin
        int bad;
        logic [7:0] pg, st;
        for (int i = 0; i < 65536; i++) prg[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            prg[16'h0200 + i] = 8'(i) ^ 8'h5A;
            oam_mem[i] = 8'h00;
        end
        reset = 1'b1;
        bus.cpu_a = 16'h0000;
        bus.cpu_o = 8'h00;
        bus.cpu_w = 1'b0;
        bus.oam_start = 8'h00;
        bus.dma_i = 8'h00;
        repeat (3) @(posedge clock25);
        #1;
        chk("reset_rdy", bus.rdy, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_dma_r", bus.dma_r, 0);
        chk("reset_oam_w", bus.oam_w, 0);
        chk("reset_dma_a", bus.dma_a, 0);
        chk("reset_oam_a", bus.oam_a, 0);
        chk("reset_oam_d", bus.oam_d, 0);
        reset = 1'b0;
        repeat (3) @(posedge clock25);

        cpu_write(16'h4015, 8'h02, 1'b0, 1'b0);
        repeat (10) @(negedge clock25);
        chk("other_addr_no_trigger", bus.busy, 0);

        run_xfer("oam_aligned", 8'h02, 8'h00, 1'b1, 1'b0);
        run_xfer("oam_odd_align", 8'h02, 8'h00, 1'b1, 1'b1);

        first_wa = -1;
        run_xfer("oam_wrap", 8'h03, 8'hF0, 1'b0, 1'b0);
        chk("wrap_first_addr", first_wa, 8'hF0);
        chk("wrap_last_addr", last_wa, 8'hEF);
        chk("wrap_oam0", oam_mem[0], prg[16'h0310]);

        ce_div = 4;
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
        run_xfer("oam_ce_1in4", 8'h02, 8'h00, 1'b0, 1'b0);
        ce_div = 1;

        bus.oam_start = 8'h10;
        cpu_write(DMA_ADDR, 8'h02, 1'b0, 1'b0);
        repeat (200) @(negedge clock25);
        chk("busy_mid_transfer", bus.busy, 1);
        cpu_write(DMA_ADDR, 8'h07, 1'b0, 1'b0);
        wait_done(6000);
        check_oam("oam_ignore_rewrite", 8'h02, 8'h10);

        for (int i = 0; i < 256; i++) oam_mem[i] = 8'(i) ^ 8'hC3;
        bus.oam_start = 8'h00;
        cpu_write(DMA_ADDR, 8'h05, 1'b0, 1'b0);
        bad = 0;
        while (wr_count < 100 && bad < 2000) begin
            @(posedge clock25);
            bad++;
        end
        chk("reset_wait_timeout", int'(bad >= 2000), 0);
        #1;
        reset = 1'b1;
        rd_q.delete();
        wr_q.delete();
        stall_q.delete();
        xfer_on = 1'b0;
        @(posedge clock25);
        #1;
        reset = 1'b0;
        chk("abort_rdy", bus.rdy, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_oam_w", bus.oam_w, 0);
        repeat (20) @(negedge clock25);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < 100 && oam_mem[i] !== prg[16'h0500 + i]) bad++;
            if (i >= 100 && oam_mem[i] !== (8'(i) ^ 8'hC3)) bad++;
        end
        chk("oam_after_abort", bad, 0);
        chk("abort_write_count", wr_count, 100);

        run_xfer("oam_after_reset", 8'h06, 8'h00, 1'b0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            pg = 8'($urandom);
            st = 8'($urandom);
            for (int i = 0; i < 256; i++) prg[{pg, 8'(i)}] = 8'($urandom);
            ce_div = int'($urandom_range(0, 3));
            run_xfer("oam_random", pg, st, 1'b0, 1'b0);
        end
        ce_div = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
